// File: rtl/mult_job_sequencer.sv
// Job controller in front of seq_mult8x8: buffers operand pairs in a small
// FIFO, launches one multiplication at a time, waits for the core's done edge
// and presents the product over a valid/ready handshake. A watchdog abandons
// jobs whose core never completes and raises a sticky error flag.
module mult_job_sequencer #(
    parameter int FIFO_DEPTH = 2,   // power of 2, >= 2
    parameter int TIMEOUT    = 15,  // max cycles spent in WAIT, >= 8
    parameter int CNT_W      = 4    // watchdog width, must hold TIMEOUT
) (
    input  logic        clk,
    input  logic        aclr_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  mult_dataa,
    output logic [7:0]  mult_datab,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [15:0] mult_product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_product,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_FW-1:0] count;
    logic [15:0]       head;
    logic              push, pop;
    logic              done_q, done_rise;
    logic              capture, expire;
    logic [CNT_W-1:0]  watchdog;

    // Full FIFO refuses pushes outright, even when the head leaves this cycle.
    assign in_ready  = (count != FULL_CNT);
    assign push      = in_valid & in_ready;
    assign head      = mem[rd_ptr];
    assign done_rise = mult_done & ~done_q;
    assign busy      = (state != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk or negedge aclr_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!aclr_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state, launch strobe and job-completion decisions.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt  = state;
        mult_start = 1'b0;
        pop        = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            ST_IDLE: begin
                // Launch only if the result register is free or being drained now.
                if ((count != '0) && (!out_valid || out_ready)) begin
                    pop       = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                mult_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    capture   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (watchdog == WD_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately left unreset; only pointers and count are.
        if (push) mem[wr_ptr] <= {in_a, in_b};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_FW'(1);
                2'b01:   count <= count - CNT_FW'(1);
                default: count <= count;
            endcase
        end
    end

    // Operands held stable for the core from launch until the next pop.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            mult_dataa <= '0;
            mult_datab <= '0;
        end else if (pop) begin
            mult_dataa <= head[15:8];
            mult_datab <= head[7:0];
        end
    end

    // Done edge detector and watchdog for the job in flight.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            done_q   <= 1'b0;
            watchdog <= '0;
        end else begin
            done_q <= mult_done;
            if (state == ST_LAUNCH)
                watchdog <= '0;
            else if (state == ST_WAIT && !capture && !expire)
                watchdog <= watchdog + CNT_W'(1);
        end
    end

    // Result register: capture wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            out_valid   <= 1'b0;
            out_product <= '0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_product <= mult_product;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky watchdog flag; a new timeout beats a same-cycle clear.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)      timeout_err <= 1'b0;
        else if (expire)  timeout_err <= 1'b1;
        else if (err_clr) timeout_err <= 1'b0;
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Self-checking bench for mult_job_sequencer with a behavioural multiplier
// core whose per-job behaviour (normal, hang, done-held-high) is queued
// alongside the operands.
module tb_mult_job_sequencer;

    localparam int LAT = 4;  // core cycles from start to done

    typedef enum logic [1:0] {M_NORMAL, M_HANG, M_HELD} mode_e;
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [7:0]  mult_dataa, mult_datab;
    logic        mult_start;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_product;
    logic        busy;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    mode_e       mode_q[$];
    bit          rand_ready = 1'b0;

    mult_job_sequencer #(.FIFO_DEPTH(2), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .aclr_n(aclr_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_start(mult_start),
        .mult_done(mult_done), .mult_product(mult_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural core: level done that drops on start and rises LAT cycles later.
    logic [15:0] m_prod;
    int          m_cnt;
    mode_e       m_mode;
    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            mult_done    <= 1'b0;
            mult_product <= '0;
            m_cnt        <= 0;
        end else if (mult_start) begin
            m_mode = (mode_q.size() != 0) ? mode_q.pop_front() : M_NORMAL;
            case (m_mode)
                M_NORMAL: begin
                    mult_done <= 1'b0;
                    m_cnt     <= LAT;
                    m_prod    <= 16'(mult_dataa) * 16'(mult_datab);
                end
                M_HANG: begin
                    mult_done <= 1'b0;
                    m_cnt     <= 0;
                end
                default: m_cnt <= 0;  // done left as it was
            endcase
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mult_done    <= 1'b1;
                mult_product <= m_prod;
            end
        end
    end

    // Random consumer back-pressure for the table phase.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard, result-hold, operand-hold and start-width monitors.
    logic        hold_pending = 1'b0;
    logic [15:0] held_prod = '0;
    logic        start_prev = 1'b0;
    logic [7:0]  lat_a = '0, lat_b = '0;
    always @(negedge clk) begin
        if (!aclr_n) begin
            hold_pending = 1'b0;
            start_prev   = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_product", out_product, held_prod);
            end
            hold_pending = out_valid && !out_ready;
            held_prod    = out_product;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got out_product=0x%0h, expected no output (t=%0t)",
                             out_product, $time);
                end else begin
                    check("sb_product", out_product, exp_q.pop_front());
                end
            end
            if (mult_start) begin
                check("start_single_cycle", start_prev, 0);
                lat_a = mult_dataa;
                lat_b = mult_datab;
            end else if (busy) begin
                check("operand_a_stable", mult_dataa, lat_a);
                check("operand_b_stable", mult_datab, lat_b);
            end
            start_prev = mult_start;
        end
    end

    // Offer one pair; it is accepted at the posedge after in_ready is seen high.
    task automatic push_job(input logic [7:0] a, input logic [7:0] b, input mode_e mode,
                            input bit has_exp, input logic [15:0] prod);
        int g = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > 300) begin
                check("push_ready_timeout", in_ready, 1);
                break;
            end
        end
        if (has_exp) exp_q.push_back(prod);
        mode_q.push_back(mode);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until no job is pending, in flight or waiting to be consumed.
    task automatic drain(input string name);
        int g = 0;
        int quiet = 0;
        while (quiet < 2 && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
            if (!busy && !out_valid && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        check(name, (quiet >= 2) ? 32'd1 : 32'd0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t vecs[8];
        int g;
        vecs[0] = '{8'h0C, 8'h0D, 16'h009C};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'h5A, 16'h0000};
        vecs[3] = '{8'h80, 8'h02, 16'h0100};
        vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[5] = '{8'hAA, 8'h55, 16'h3872};
        vecs[6] = '{8'h7F, 8'h81, 16'h3FFF};
        vecs[7] = '{8'h10, 8'h10, 16'h0100};

        // Reset state, observed without any clock edge dependence.
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start", mult_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_dataa", mult_dataa, 0);
        check("rst_timeout_err", timeout_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        aclr_n = 1'b1;
        @(posedge clk);
        #1;

        // Single job: launch latency, one-cycle start, result timing.
        out_ready = 1'b1;
        push_job(8'h0C, 8'h0D, M_NORMAL, 1, 16'h009C);
        check("t1_no_start_at_push", mult_start, 0);
        check("t1_idle_at_push", busy, 0);
        @(posedge clk);
        #1;
        check("t1_start_high", mult_start, 1);
        check("t1_busy", busy, 1);
        check("t1_dataa", mult_dataa, 8'h0C);
        check("t1_datab", mult_datab, 8'h0D);
        @(posedge clk);
        #1;
        check("t1_start_low", mult_start, 0);
        g = 0;
        while (!mult_done && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("t1_done_seen", mult_done, 1);
        check("t1_valid_before_capture", out_valid, 0);
        @(posedge clk);
        #1;
        check("t1_valid_after_capture", out_valid, 1);
        check("t1_product", out_product, 16'h009C);
        @(posedge clk);
        #1;
        check("t1_valid_one_cycle", out_valid, 0);
        drain("t1_drain");
        check("t1_in_ready_after", in_ready, 1);

        // Back-pressure: FIFO fills, result held, in-order delivery.
        out_ready = 1'b0;
        push_job(8'hFF, 8'hFF, M_NORMAL, 1, 16'hFE01);
        push_job(8'h00, 8'h5A, M_NORMAL, 1, 16'h0000);
        push_job(8'h80, 8'h02, M_NORMAL, 1, 16'h0100);
        check("t2_full_in_ready", in_ready, 0);
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("t2_first_valid", out_valid, 1);
        repeat (20) @(posedge clk);
        #1;
        check("t2_held_product", out_product, 16'hFE01);
        check("t2_no_launch_while_held", busy, 0);
        check("t2_dataa_unchanged", mult_dataa, 8'hFF);
        check("t2_still_full", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("t2_no_pass_through", in_ready, 0);
        drain("t2_drain");

        // Push and pop in the same cycle at count=1.
        push_job(8'h03, 8'h05, M_NORMAL, 1, 16'h000F);
        push_job(8'h07, 8'h09, M_NORMAL, 1, 16'h003F);
        check("t6_count_one_ready", in_ready, 1);
        push_job(8'h0B, 8'h0D, M_NORMAL, 1, 16'h008F);
        check("t6_count_two_full", in_ready, 0);
        drain("t6_drain");

        // Table of jobs under random consumer back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            push_job(vecs[i].a, vecs[i].b, M_NORMAL, 1, vecs[i].prod);
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain("table_drain");

        // done already high at launch and never falls: no edge, so a timeout.
        push_job(8'h21, 8'h02, M_HELD, 0, 16'h0000);
        g = 0;
        while (!timeout_err && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("t4_held_timeout", timeout_err, 1);
        check("t4_held_no_output", out_valid, 0);
        drain("t4_drain");
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("t4_err_cleared", timeout_err, 0);

        // Hung core: exact timeout edge, next queued job launches, err_clr.
        push_job(8'h11, 8'h22, M_HANG, 0, 16'h0000);
        push_job(8'h05, 8'h06, M_NORMAL, 1, 16'h001E);
        repeat (15) @(posedge clk);
        #1;
        check("t3_no_err_before_limit", timeout_err, 0);
        check("t3_still_waiting", busy, 1);
        @(posedge clk);
        #1;
        check("t3_err_at_limit", timeout_err, 1);
        check("t3_back_to_idle", busy, 0);
        check("t3_no_output", out_valid, 0);
        @(posedge clk);
        #1;
        check("t3_next_launch", mult_start, 1);
        check("t3_next_dataa", mult_dataa, 8'h05);
        drain("t3_drain");
        check("t3_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        check("t3_err_clr", timeout_err, 0);
        push_job(8'h44, 8'h55, M_HANG, 0, 16'h0000);
        repeat (16) @(posedge clk);
        #1;
        check("t3_clr_holds_low", timeout_err, 0);
        @(posedge clk);
        #1;
        check("t3_set_beats_clr", timeout_err, 1);
        err_clr = 1'b0;
        drain("t3b_drain");

        // Asynchronous reset mid-WAIT with two jobs queued.
        push_job(8'h31, 8'h32, M_HANG, 0, 16'h0000);
        push_job(8'h41, 8'h42, M_NORMAL, 1, 16'h10C2);
        push_job(8'h51, 8'h52, M_NORMAL, 1, 16'h19F2);
        repeat (3) @(posedge clk);
        #2;
        check("t5_busy_before_reset", busy, 1);
        aclr_n = 1'b0;
        exp_q.delete();
        mode_q.delete();
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_dataa", mult_dataa, 0);
        check("t5_rst_datab", mult_datab, 0);
        check("t5_rst_start", mult_start, 0);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_out_product", out_product, 0);
        check("t5_rst_err", timeout_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        aclr_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t5_post_busy", busy, 0);
        check("t5_post_in_ready", in_ready, 1);
        check("t5_post_no_stale", out_valid, 0);
        push_job(8'h06, 8'h07, M_NORMAL, 1, 16'h002A);
        drain("t5_recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
